lsu: RTL and testbench

Load/store stage of the five-stage pipeline, between the execute stage and the combinational writeback unit. It takes one execute-stage result per cycle, issues loads and stores on an SRAM-like data bus with address and data handshakes, and stalls upstream until the access completes. It extracts and extends load bytes and registers the fields the writeback unit consumes (`mem_alu_res`, `mem_w_reg_ena`, `mem_w_reg_dst`, `mem_r_data`, `mem_wb_sel`).

---
 rtl/lsu_if.sv | 25 ++
 rtl/lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: SRAM-like data bus between the load/store stage and memory.
// master: data_req/wr/size/addr/wstrb/wdata out; data_addr_ok/data_ok/rdata in.
interface lsu_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr,
        output data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr,
        input  data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store stage; issues bus accesses, stalls upstream, extends loads.
// Ports: clk, rst (sync, high), ex_* op in, flush, lsu_stall, bus (lsu_if.master),
// mem_* writeback fields, mem_adel/ades/badvaddr (live with LSU_ALIGN_CHECK_EN).
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic        ex_w_reg_ena,
    input  logic [4:0]  ex_w_reg_dst,
    input  logic [3:0]  ex_ls_op,
    input  logic [31:0] ex_rt_data,
    input  logic        flush,
    output logic        lsu_stall,
    lsu_if.master       bus,
    output logic [31:0] mem_alu_res,
    output logic        mem_w_reg_ena,
    output logic [4:0]  mem_w_reg_dst,
    output logic [31:0] mem_r_data,
    output logic        mem_wb_sel,
    output logic        mem_adel,
    output logic        mem_ades,
    output logic [31:0] mem_badvaddr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [1:0]  state;
    logic        killed;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_rt;
    logic [4:0]  r_dst;
    logic        r_wena;

    logic ex_is_load;
    logic ex_is_store;
    logic ex_mis;
    logic accept;
    logic pass;
    logic r_is_load;

    assign ex_is_load  = (ex_ls_op >= OP_LB) && (ex_ls_op <= OP_LW);
    assign ex_is_store = (ex_ls_op >= OP_SB) && (ex_ls_op <= OP_SW);
    assign r_is_load   = (r_op >= OP_LB) && (r_op <= OP_LW);

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        ex_mis = 1'b0;
        case (ex_ls_op)
            OP_LH, OP_LHU, OP_SH: ex_mis = ex_alu_res[0];
            OP_LW, OP_SW:         ex_mis = |ex_alu_res[1:0];
            default:              ex_mis = 1'b0;
        endcase
    end
`else
    assign ex_mis = 1'b0;
`endif

    // Non-memory ops and trapped misaligned ops both take the 1-cycle path.
    assign pass   = (state == S_IDLE) && ex_valid && !flush &&
                    (!(ex_is_load || ex_is_store) || ex_mis);
    assign accept = (state == S_IDLE) && ex_valid && !flush &&
                    (ex_is_load || ex_is_store) && !ex_mis;

    assign lsu_stall = accept || (state == S_REQ) ||
                       ((state == S_WAIT) && !bus.data_data_ok);

    // Bus fields come only from the request register, so they hold in REQ.
    logic [1:0]  size_c;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;

    always_comb begin
        size_c  = 2'd0;
        strb_c  = 4'b0000;
        wdata_c = r_rt;
        case (r_op)
            OP_LB, OP_LBU: size_c = 2'd0;
            OP_LH, OP_LHU: size_c = 2'd1;
            OP_LW:         size_c = 2'd2;
            OP_SB: begin
                size_c  = 2'd0;
                strb_c  = 4'b0001 << r_addr[1:0];
                wdata_c = {4{r_rt[7:0]}};
            end
            OP_SH: begin
                size_c  = 2'd1;
                strb_c  = 4'b0011 << r_addr[1:0];
                wdata_c = {2{r_rt[15:0]}};
            end
            OP_SW: begin
                size_c  = 2'd2;
                strb_c  = 4'b1111;
            end
            default: ;
        endcase
    end

    assign bus.data_req   = (state == S_REQ);
    assign bus.data_wr    = (r_op >= OP_SB) && (r_op <= OP_SW);
    assign bus.data_size  = size_c;
    assign bus.data_addr  = r_addr;
    assign bus.data_wstrb = strb_c;
    assign bus.data_wdata = wdata_c;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign ld_byte = bus.data_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign ld_half = r_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];

    always_comb begin
        ld_val = 32'd0;
        case (r_op)
            OP_LB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: ld_val = {24'd0, ld_byte};
            OP_LH:  ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU: ld_val = {16'd0, ld_half};
            OP_LW:  ld_val = bus.data_rdata;
            default: ld_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            killed        <= 1'b0;
            r_op          <= 4'd0;
            r_addr        <= 32'd0;
            r_rt          <= 32'd0;
            r_dst         <= 5'd0;
            r_wena        <= 1'b0;
            mem_alu_res   <= 32'd0;
            mem_w_reg_ena <= 1'b0;
            mem_w_reg_dst <= 5'd0;
            mem_r_data    <= 32'd0;
            mem_wb_sel    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    killed <= 1'b0;
                    if (pass) begin
                        mem_alu_res   <= ex_alu_res;
                        mem_w_reg_ena <= ex_w_reg_ena && !ex_mis;
                        mem_w_reg_dst <= ex_w_reg_dst;
                        mem_r_data    <= 32'd0;
                        mem_wb_sel    <= 1'b0;
                    end else if (accept) begin
                        r_op          <= ex_ls_op;
                        r_addr        <= ex_alu_res;
                        r_rt          <= ex_rt_data;
                        r_dst         <= ex_w_reg_dst;
                        r_wena        <= ex_w_reg_ena;
                        mem_w_reg_ena <= 1'b0;
                        state         <= S_REQ;
                    end else begin
                        mem_w_reg_ena <= 1'b0;
                    end
                end
                S_REQ: begin
                    mem_w_reg_ena <= 1'b0;
                    // An accepted request must drain even when flushed.
                    if (bus.data_addr_ok) begin
                        state <= S_WAIT;
                        if (flush) killed <= 1'b1;
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        mem_alu_res   <= r_addr;
                        mem_w_reg_dst <= r_dst;
                        mem_w_reg_ena <= r_wena && r_is_load && !killed && !flush;
                        mem_wb_sel    <= r_is_load;
                        mem_r_data    <= r_is_load ? ld_val : 32'd0;
                        killed        <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        mem_w_reg_ena <= 1'b0;
                        if (flush) killed <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    // Flags describe only the op that passed through on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_adel     <= 1'b0;
            mem_ades     <= 1'b0;
            mem_badvaddr <= 32'd0;
        end else begin
            mem_adel     <= pass && ex_mis && ex_is_load;
            mem_ades     <= pass && ex_mis && ex_is_store;
            mem_badvaddr <= (pass && ex_mis) ? ex_alu_res : 32'd0;
        end
    end
`else
    assign mem_adel     = 1'b0;
    assign mem_ades     = 1'b0;
    assign mem_badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a scripted bus slave.
// Each task drives one scenario and checks its own results.
module tb_lsu;
    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_res;
    logic        ex_w_reg_ena;
    logic [4:0]  ex_w_reg_dst;
    logic [3:0]  ex_ls_op;
    logic [31:0] ex_rt_data;
    logic        flush;
    logic        lsu_stall;
    logic [31:0] mem_alu_res;
    logic        mem_w_reg_ena;
    logic [4:0]  mem_w_reg_dst;
    logic [31:0] mem_r_data;
    logic        mem_wb_sel;
    logic        mem_adel;
    logic        mem_ades;
    logic [31:0] mem_badvaddr;

    lsu_if bus ();

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_alu_res   (ex_alu_res),
        .ex_w_reg_ena (ex_w_reg_ena),
        .ex_w_reg_dst (ex_w_reg_dst),
        .ex_ls_op     (ex_ls_op),
        .ex_rt_data   (ex_rt_data),
        .flush        (flush),
        .lsu_stall    (lsu_stall),
        .bus          (bus),
        .mem_alu_res  (mem_alu_res),
        .mem_w_reg_ena(mem_w_reg_ena),
        .mem_w_reg_dst(mem_w_reg_dst),
        .mem_r_data   (mem_r_data),
        .mem_wb_sel   (mem_wb_sel),
        .mem_adel     (mem_adel),
        .mem_ades     (mem_ades),
        .mem_badvaddr (mem_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          stall_cnt;
    int          dup_wb;
    logic        req_stable;
    logic        cap_wr;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;

    // Scripted access: accept, 'delay' cycles without addr_ok, addr_ok,
    // optional flushed WAIT cycle, then data_ok. Leaves time at edge+1.
    task automatic mem_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] rt, input logic [31:0] rd,
                              input int delay, input bit fl);
        ex_valid     = 1'b1;
        ex_ls_op     = op;
        ex_alu_res   = addr;
        ex_rt_data   = rt;
        ex_w_reg_ena = 1'b1;
        ex_w_reg_dst = 5'd9;
        stall_cnt    = 0;
        dup_wb       = 0;
        req_stable   = 1'b1;
        #1;
        if (lsu_stall) stall_cnt++;
        @(posedge clk); #1;
        cap_wr    = bus.data_wr;
        cap_size  = bus.data_size;
        cap_addr  = bus.data_addr;
        cap_wstrb = bus.data_wstrb;
        cap_wdata = bus.data_wdata;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) bus.data_addr_ok = 1'b1;
            #1;
            if (bus.data_req !== 1'b1 || bus.data_wr !== cap_wr ||
                bus.data_size !== cap_size || bus.data_addr !== cap_addr ||
                bus.data_wstrb !== cap_wstrb || bus.data_wdata !== cap_wdata)
                req_stable = 1'b0;
            if (lsu_stall) stall_cnt++;
            if (mem_w_reg_ena) dup_wb++;
            @(posedge clk); #1;
        end
        bus.data_addr_ok = 1'b0;
        if (fl) begin
            flush = 1'b1;
            #1;
            if (lsu_stall) stall_cnt++;
            if (mem_w_reg_ena) dup_wb++;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        bus.data_rdata   = rd;
        bus.data_data_ok = 1'b1;
        #1;
        if (lsu_stall) stall_cnt++;
        if (mem_w_reg_ena) dup_wb++;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        ex_valid = 1'b0;
        ex_ls_op = 4'd0;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] dst, input logic wena);
        ex_valid     = 1'b1;
        ex_ls_op     = 4'd0;
        ex_alu_res   = res;
        ex_w_reg_dst = dst;
        ex_w_reg_ena = wena;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ex_valid = 1'b0; ex_alu_res = 32'd0; ex_w_reg_ena = 1'b0;
        ex_w_reg_dst = 5'd0; ex_ls_op = 4'd0; ex_rt_data = 32'd0; flush = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        checks++; if (mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL rst_wena got %b want 0", mem_w_reg_ena); end
        checks++; if (mem_alu_res !== 32'd0) begin errors++; $display("FAIL rst_alu got %h want 0", mem_alu_res); end
        checks++; if (mem_r_data !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", mem_r_data); end
        checks++; if (mem_wb_sel !== 1'b0 || mem_w_reg_dst !== 5'd0) begin errors++; $display("FAIL rst_sel_dst got %b/%h want 0/0", mem_wb_sel, mem_w_reg_dst); end
        checks++; if (bus.data_req !== 1'b0 || lsu_stall !== 1'b0) begin errors++; $display("FAIL rst_req_stall got %b/%b want 0/0", bus.data_req, lsu_stall); end
        checks++; if (mem_adel !== 1'b0 || mem_ades !== 1'b0 || mem_badvaddr !== 32'd0) begin errors++; $display("FAIL rst_flags got %b/%b/%h want 0", mem_adel, mem_ades, mem_badvaddr); end
    endtask

    task automatic test_alu;
        ex_valid = 1'b1; ex_ls_op = 4'd0; ex_alu_res = 32'h1234_5678;
        ex_w_reg_dst = 5'd7; ex_w_reg_ena = 1'b1;
        #1;
        checks++; if (lsu_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", lsu_stall); end
        @(posedge clk); #1;
        checks++; if (mem_alu_res !== 32'h1234_5678) begin errors++; $display("FAIL alu_res got %h want 12345678", mem_alu_res); end
        checks++; if (mem_w_reg_ena !== 1'b1 || mem_w_reg_dst !== 5'd7) begin errors++; $display("FAIL alu_wr got %b/%0d want 1/7", mem_w_reg_ena, mem_w_reg_dst); end
        checks++; if (mem_wb_sel !== 1'b0 || mem_r_data !== 32'd0) begin errors++; $display("FAIL alu_sel got %b/%h want 0/0", mem_wb_sel, mem_r_data); end
        ex_ls_op = 4'd12; ex_alu_res = 32'hA5A5_0001; ex_w_reg_dst = 5'd3;
        #1;
        checks++; if (lsu_stall !== 1'b0 || bus.data_req !== 1'b0) begin errors++; $display("FAIL op12_stall got %b/%b want 0/0", lsu_stall, bus.data_req); end
        @(posedge clk); #1;
        checks++; if (mem_alu_res !== 32'hA5A5_0001 || mem_w_reg_dst !== 5'd3) begin errors++; $display("FAIL op12_res got %h/%0d want a5a50001/3", mem_alu_res, mem_w_reg_dst); end
        flush = 1'b1; ex_ls_op = 4'd0; ex_alu_res = 32'h0000_00FF;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL flush_idle_wena got %b want 0", mem_w_reg_ena); end
        alu_op(32'h0000_0042, 5'd4, 1'b1);
        @(posedge clk); #1;
        checks++; if (mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL invalid_bubble got %b want 0", mem_w_reg_ena); end
    endtask

    task automatic test_load;
        alu_op(32'h0000_0001, 5'd1, 1'b1);
        mem_access(4'd1, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b0);
        checks++; if (mem_r_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", mem_r_data); end
        checks++; if (mem_wb_sel !== 1'b1 || mem_w_reg_ena !== 1'b1 || mem_w_reg_dst !== 5'd9) begin errors++; $display("FAIL lb_wb got %b/%b/%0d want 1/1/9", mem_wb_sel, mem_w_reg_ena, mem_w_reg_dst); end
        checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL lb_stall got %0d want 2", stall_cnt); end
        checks++; if (dup_wb !== 0) begin errors++; $display("FAIL lb_bubble got %0d want 0", dup_wb); end
        checks++; if (cap_wr !== 1'b0 || cap_size !== 2'd0 || cap_addr !== 32'h0000_1003) begin errors++; $display("FAIL lb_req got %b/%0d/%h want 0/0/1003", cap_wr, cap_size, cap_addr); end
        checks++; if (mem_alu_res !== 32'h0000_1003) begin errors++; $display("FAIL lb_alu got %h want 1003", mem_alu_res); end
        mem_access(4'd4, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0, 1'b0);
        checks++; if (mem_r_data !== 32'h0000_BEEF || cap_size !== 2'd1) begin errors++; $display("FAIL lhu_data got %h/%0d want 0000beef/1", mem_r_data, cap_size); end
        mem_access(4'd3, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0, 1'b0);
        checks++; if (mem_r_data !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data got %h want ffffbeef", mem_r_data); end
        mem_access(4'd2, 32'h0000_1001, 32'd0, 32'h80FF_9234, 0, 1'b0);
        checks++; if (mem_r_data !== 32'h0000_0092) begin errors++; $display("FAIL lbu_data got %h want 00000092", mem_r_data); end
        mem_access(4'd3, 32'h0000_2000, 32'd0, 32'h1234_7FFE, 0, 1'b0);
        checks++; if (mem_r_data !== 32'h0000_7FFE) begin errors++; $display("FAIL lh_lo got %h want 00007ffe", mem_r_data); end
    endtask

    task automatic test_store;
        mem_access(4'd6, 32'h0000_3001, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 1'b0);
        checks++; if (cap_wdata !== 32'hABAB_ABAB || cap_wstrb !== 4'b0010) begin errors++; $display("FAIL sb_bus got %h/%b want abababab/0010", cap_wdata, cap_wstrb); end
        checks++; if (cap_wr !== 1'b1 || cap_size !== 2'd0) begin errors++; $display("FAIL sb_ctl got %b/%0d want 1/0", cap_wr, cap_size); end
        checks++; if (mem_w_reg_ena !== 1'b0 || mem_wb_sel !== 1'b0) begin errors++; $display("FAIL sb_wb got %b/%b want 0/0", mem_w_reg_ena, mem_wb_sel); end
        mem_access(4'd7, 32'h0000_3002, 32'h1234_5678, 32'd0, 0, 1'b0);
        checks++; if (cap_wdata !== 32'h5678_5678 || cap_wstrb !== 4'b1100 || cap_size !== 2'd1) begin errors++; $display("FAIL sh_bus got %h/%b/%0d want 56785678/1100/1", cap_wdata, cap_wstrb, cap_size); end
        mem_access(4'd8, 32'h0000_3004, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        checks++; if (cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'b1111 || cap_size !== 2'd2 || cap_addr !== 32'h0000_3004) begin errors++; $display("FAIL sw_bus got %h/%b/%0d/%h want deadbeef/1111/2/3004", cap_wdata, cap_wstrb, cap_size, cap_addr); end
    endtask

    task automatic test_addr_delay;
        alu_op(32'h0000_0002, 5'd2, 1'b1);
        mem_access(4'd5, 32'h0000_0010, 32'd0, 32'hCAFE_F00D, 4, 1'b0);
        checks++; if (req_stable !== 1'b1) begin errors++; $display("FAIL dly_stable got %b want 1", req_stable); end
        checks++; if (stall_cnt !== 6) begin errors++; $display("FAIL dly_stall got %0d want 6", stall_cnt); end
        checks++; if (dup_wb !== 0) begin errors++; $display("FAIL dly_bubble got %0d want 0", dup_wb); end
        checks++; if (mem_w_reg_ena !== 1'b1 || mem_r_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL dly_wb got %b/%h want 1/cafef00d", mem_w_reg_ena, mem_r_data); end
        @(posedge clk); #1;
        checks++; if (mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL dly_single got %b want 0", mem_w_reg_ena); end
    endtask

    task automatic test_flush_wait;
        mem_access(4'd5, 32'h0000_0020, 32'd0, 32'h0000_0001, 0, 1'b1);
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL fw_stall got %0d want 3", stall_cnt); end
        checks++; if (mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL fw_wena got %b want 0", mem_w_reg_ena); end
        #1;
        checks++; if (lsu_stall !== 1'b0 || bus.data_req !== 1'b0) begin errors++; $display("FAIL fw_idle got %b/%b want 0/0", lsu_stall, bus.data_req); end
        alu_op(32'h0000_0077, 5'd5, 1'b1);
        checks++; if (mem_w_reg_ena !== 1'b1 || mem_alu_res !== 32'h0000_0077) begin errors++; $display("FAIL fw_next got %b/%h want 1/77", mem_w_reg_ena, mem_alu_res); end
    endtask

    task automatic test_flush_req;
        ex_valid = 1'b1; ex_ls_op = 4'd5; ex_alu_res = 32'h0000_0030; ex_w_reg_ena = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL fr_req got %b want 1", bus.data_req); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_ls_op = 4'd0;
        #1;
        checks++; if (bus.data_req !== 1'b0 || lsu_stall !== 1'b0 || mem_w_reg_ena !== 1'b0) begin errors++; $display("FAIL fr_abandon got %b/%b/%b want 0/0/0", bus.data_req, lsu_stall, mem_w_reg_ena); end
    endtask

    task automatic test_reset_mid;
        ex_valid = 1'b1; ex_ls_op = 4'd5; ex_alu_res = 32'h0000_0040; ex_w_reg_ena = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0; ex_ls_op = 4'd0;
        bus.data_rdata = 32'h5555_AAAA; bus.data_data_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        checks++; if (mem_w_reg_ena !== 1'b0 || mem_r_data !== 32'd0 || lsu_stall !== 1'b0) begin errors++; $display("FAIL rm_ignore got %b/%h/%b want 0/0/0", mem_w_reg_ena, mem_r_data, lsu_stall); end
    endtask

    task automatic test_align;
`ifdef LSU_ALIGN_CHECK_EN
        ex_valid = 1'b1; ex_ls_op = 4'd5; ex_alu_res = 32'h0000_4002; ex_w_reg_ena = 1'b1;
        #1;
        checks++; if (lsu_stall !== 1'b0 || bus.data_req !== 1'b0) begin errors++; $display("FAIL al_nostall got %b/%b want 0/0", lsu_stall, bus.data_req); end
        @(posedge clk); #1;
        ex_ls_op = 4'd8;
        checks++; if (mem_adel !== 1'b1 || mem_ades !== 1'b0 || mem_badvaddr !== 32'h0000_4002) begin errors++; $display("FAIL al_adel got %b/%b/%h want 1/0/4002", mem_adel, mem_ades, mem_badvaddr); end
        checks++; if (mem_w_reg_ena !== 1'b0 || bus.data_req !== 1'b0) begin errors++; $display("FAIL al_wena got %b/%b want 0/0", mem_w_reg_ena, bus.data_req); end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ls_op = 4'd0;
        checks++; if (mem_ades !== 1'b1 || mem_adel !== 1'b0) begin errors++; $display("FAIL al_ades got %b/%b want 1/0", mem_ades, mem_adel); end
        @(posedge clk); #1;
        checks++; if (mem_ades !== 1'b0 || mem_badvaddr !== 32'd0) begin errors++; $display("FAIL al_hold got %b/%h want 0/0", mem_ades, mem_badvaddr); end
`else
        mem_access(4'd5, 32'h0000_4002, 32'd0, 32'h1122_3344, 0, 1'b0);
        checks++; if (cap_addr !== 32'h0000_4002 || mem_r_data !== 32'h1122_3344) begin errors++; $display("FAIL mis_issue got %h/%h want 4002/11223344", cap_addr, mem_r_data); end
        checks++; if (mem_adel !== 1'b0 || mem_badvaddr !== 32'd0) begin errors++; $display("FAIL mis_flags got %b/%h want 0/0", mem_adel, mem_badvaddr); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_addr_delay();
        test_flush_wait();
        test_flush_req();
        test_reset_mid();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
